dm_arbiter: RTL

//  Two-requester arbiter sharing the single-port word data memory (3072 x 32, async read, write on clk edge).

---
 rtl/dm_arbiter_pkg.sv | 10 +
 rtl/dm_arbiter_if.sv | 17 +
 rtl/dm_arbiter_rr_arb2.sv | 9 +
 rtl/dm_arbiter.sv | 94 +++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared parameters, FSM state encoding and port ids for the data-memory arbiter
package dm_arbiter_pkg;
  localparam int DM_DATA_W = 32;
  localparam int DM_ADDR_W = 32;
  localparam int DM_DEPTH_WORDS = 3072;
  localparam int DM_MEM_AW = 12;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;
  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: one requester port of the data-memory arbiter
//   master = requester (drives req/we/addr/wdata), slave = arbiter (drives gnt/rvalid/rdata/rerr)
interface dm_arbiter_if #(
  parameter int DATA_W = dm_arbiter_pkg::DM_DATA_W,
  parameter int ADDR_W = dm_arbiter_pkg::DM_ADDR_W
);
  logic req;
  logic we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic gnt;
  logic rvalid;
  logic [DATA_W-1:0] rdata;
  logic rerr;
  modport master(output req, we, addr, wdata, input gnt, rvalid, rdata, rerr);
  modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata, rerr);
endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker
//   req_i[1:0] requests, last_i = port granted last time, gnt_o one-hot winner
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  assign gnt_o = {req_i[1] & (~req_i[0] | ~last_i), req_i[0] & (~req_i[1] | last_i)};
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of a single-port word data memory
//   clk, rst_n (async active-low); m0_io/m1_io requester ports (slave modport);
//   mem_addr_o/mem_wdata_o/mem_we_o to memory, mem_rdata_i combinational read data back
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int DATA_W = DM_DATA_W,
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int MEM_AW = DM_MEM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  dm_arbiter_if.slave       m0_io,
  dm_arbiter_if.slave       m1_io,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH_WORDS * 4);
  state_e state_q, state_d;
  logic last_q, last_d, id_q, id_d, we_q, we_d, in_range;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0] req, pick, gnt, rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  assign req = {m1_io.req, m0_io.req};
  rr_arb2 u_rr (.req_i(req), .last_i(last_q), .gnt_o(pick));
  // The latched request drives memory directly, so mem_addr/mem_wdata hold their last values in IDLE
  assign in_range = {1'b0, addr_q} < LIMIT;
  assign mem_addr_o = addr_q[MEM_AW+1:2];
  assign mem_wdata_o = wdata_q;
  assign mem_we_o = (state_q == ST_ACCESS) & we_q & in_range;
  assign m0_io.gnt = gnt[0];
  assign m1_io.gnt = gnt[1];
  assign m0_io.rvalid = rvalid_q[0];
  assign m1_io.rvalid = rvalid_q[1];
  assign m0_io.rdata = rdata_q[0];
  assign m1_io.rdata = rdata_q[1];
  assign m0_io.rerr = rerr_q[0];
  assign m1_io.rerr = rerr_q[1];
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    gnt = '0;
    rvalid_d = '0;
    rdata_d = rdata_q;
    rerr_d = rerr_q;
    if (state_q == ST_IDLE) begin
      gnt = pick;
      if (|pick) begin
        state_d = ST_ACCESS;
        last_d = pick[1] ? ID_M1 : ID_M0;
        id_d = pick[1] ? ID_M1 : ID_M0;
        we_d = pick[1] ? m1_io.we : m0_io.we;
        addr_d = pick[1] ? m1_io.addr : m0_io.addr;
        wdata_d = pick[1] ? m1_io.wdata : m0_io.wdata;
      end
    end else begin
      state_d = ST_IDLE;
      rvalid_d[id_q] = 1'b1;
      rdata_d[id_q] = in_range ? mem_rdata_i : '0;
      rerr_d[id_q] = ~in_range;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q <= ID_M1;
      id_q <= ID_M0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rvalid_q <= '0;
      rdata_q <= '0;
      rerr_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rerr_q <= rerr_d;
    end
  end
endmodule
